// File: rtl/puf_response_collector.sv
// Purpose: sequences RESP_BITS ring-oscillator arbiter races and packs the winner bits into one response word.
// Latency: start to done = 1 + sum over challenges of (CLR_CYCLES + measure cycles + 1); measure <= TIMEOUT.
// Backpressure: none; start is accepted only in IDLE and ignored while busy or in the done cycle.
module puf_response_collector #(
  parameter int RESP_BITS  = 8,
  parameter int IDX_W      = 3,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 arb_resp,
  input  logic                 arb_finish,
  output logic                 arb_rst,
  output logic                 ro_en,
  output logic [IDX_W-1:0]     chal_idx,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [TMR_W-1:0]      timer, timer_nxt;
  logic [CLR_W-1:0]      clr_cnt, clr_nxt;
  logic                  cap_bit, cap_nxt;
  logic [RESP_BITS-1:0]  resp_nxt;
  logic                  err_nxt;

  // Arbiter reset follows the system reset combinationally so the RO counters are
  // held cleared for the whole reset window, not just from the next edge.
  assign arb_rst = rst | (state == S_CLEAR);
  assign ro_en   = (state == S_MEASURE);
  assign busy    = (state == S_CLEAR) | (state == S_MEASURE) | (state == S_CAPTURE);
  assign done    = (state == S_DONE);

  // Next-state and datapath update for the challenge sequencer.
  always_comb begin
    state_nxt = state;
    idx_nxt   = chal_idx;
    timer_nxt = timer;
    clr_nxt   = clr_cnt;
    cap_nxt   = cap_bit;
    resp_nxt  = response;
    err_nxt   = timeout_err;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          idx_nxt   = '0;
          resp_nxt  = '0;
          err_nxt   = 1'b0;
          clr_nxt   = '0;
        end
      end

      S_CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt = S_MEASURE;
          timer_nxt = '0;
        end else begin
          clr_nxt = clr_cnt + CLR_W'(1);
        end
      end

      S_MEASURE: begin
        timer_nxt = timer + TMR_W'(1);
        // A decision in the last allowed cycle still counts as a real result.
        if (arb_finish) begin
          cap_nxt   = arb_resp;
          state_nxt = S_CAPTURE;
        end else if (timer == TMR_LAST) begin
          cap_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        for (int i = 0; i < RESP_BITS; i++) begin
          if (chal_idx == IDX_W'(i)) begin
            resp_nxt[i] = cap_bit;
          end
        end
        if (chal_idx == IDX_LAST) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = chal_idx + IDX_W'(1);
          clr_nxt   = '0;
          state_nxt = S_CLEAR;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      chal_idx    <= '0;
      timer       <= '0;
      clr_cnt     <= '0;
      cap_bit     <= 1'b0;
      response    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      chal_idx    <= idx_nxt;
      timer       <= timer_nxt;
      clr_cnt     <= clr_nxt;
      cap_bit     <= cap_nxt;
      response    <= resp_nxt;
      timeout_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// Purpose: self-checking bench for puf_response_collector with a registered arbiter model and run scoreboard.
// Latency: checks start-to-done cycle counts and per-challenge measure lengths against a reference model.
// Backpressure: exercises ignored start pulses while busy and in the done cycle.
module tb_puf_response_collector;

  localparam int RESP_BITS  = 8;
  localparam int IDX_W      = 3;
  localparam int CLR_CYCLES = 2;
  localparam int TIMEOUT    = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 arb_resp;
  logic                 arb_finish;
  logic                 arb_rst;
  logic                 ro_en;
  logic [IDX_W-1:0]     chal_idx;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic                 timeout_err;

  puf_response_collector #(
    .RESP_BITS (RESP_BITS),
    .IDX_W     (IDX_W),
    .CLR_CYCLES(CLR_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .arb_resp   (arb_resp),
    .arb_finish (arb_finish),
    .arb_rst    (arb_rst),
    .ro_en      (ro_en),
    .chal_idx   (chal_idx),
    .busy       (busy),
    .done       (done),
    .response   (response),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RESP_BITS-1:0] resp;
    logic                 err;
    logic [15:0]          lat;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;

  // fin_tbl[i] = MEASURE cycle (1-based) in which finish rises for challenge i; 0 = never.
  int fin_tbl  [RESP_BITS];
  int resp_tbl [RESP_BITS];
  int exp_mlen [RESP_BITS];
  int mlen     [RESP_BITS];

  int m_cnt = 0;
  logic m_fin = 1'b0;
  int mon_viol = 0;
  logic [IDX_W-1:0] prev_idx = '0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter model: counters cleared by arb_rst, registered finish raised in the chosen MEASURE cycle.
  always @(posedge clk) begin
    if (arb_rst) begin
      m_cnt <= 0;
      m_fin <= 1'b0;
    end else if (ro_en) begin
      m_cnt <= m_cnt + 1;
      if (fin_tbl[chal_idx] != 0 && (m_cnt + 1) == fin_tbl[chal_idx] - 1) m_fin <= 1'b1;
    end
  end

  assign arb_finish = m_fin;
  assign arb_resp   = resp_tbl[chal_idx][0];

  // Protocol monitor: ro_en only in MEASURE, chal_idx steps by one from zero and stays in range.
  always @(negedge clk) begin
    if (!rst) begin
      if (ro_en && (arb_rst || !busy || done)) mon_viol++;
      if (int'(chal_idx) > RESP_BITS - 1) mon_viol++;
      if (busy && !prev_busy && chal_idx != '0) mon_viol++;
      if (busy && prev_busy && chal_idx != prev_idx && chal_idx != prev_idx + IDX_W'(1)) mon_viol++;
      if (ro_en) mlen[chal_idx]++;
      prev_idx  = chal_idx;
      prev_busy = busy;
    end
  end

  task automatic set_tables(input int fin, input int rmode);
    for (int i = 0; i < RESP_BITS; i++) begin
      fin_tbl[i]  = fin;
      resp_tbl[i] = (rmode == 2) ? (i & 1) : rmode;
    end
  endtask

  task automatic launch(input bit do_push);
    exp_t e;
    int lat;
    int m;
    e.resp = '0;
    e.err  = 1'b0;
    lat    = 1;
    for (int i = 0; i < RESP_BITS; i++) begin
      m = fin_tbl[i];
      if (m >= 2 && m <= TIMEOUT) begin
        e.resp[i] = resp_tbl[i][0];
      end else begin
        m = TIMEOUT;
        e.err = 1'b1;
      end
      lat += CLR_CYCLES + m + 1;
      exp_mlen[i] = m;
      mlen[i] = 0;
    end
    e.lat = 16'(lat);
    if (do_push) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_idx0", 32'(chal_idx), 32'd0);
    check("launch_arb_rst", 32'(arb_rst), 32'd1);
    check("launch_resp_clr", 32'(response), 32'd0);
    check("launch_err_clr", 32'(timeout_err), 32'd0);
  endtask

  task automatic wait_done(input bit noise, input bit start_in_done);
    exp_t e;
    bit seen;
    int t_done;
    seen = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (noise) start = ($urandom_range(0, 3) == 0);
    end
    start = start_in_done;
    t_done = cyc;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      start = 1'b0;
      return;
    end
    check("response", 32'(response), 32'(e.resp));
    check("timeout_err", 32'(timeout_err), 32'(e.err));
    check("latency", 32'(t_done - t0), 32'(e.lat));
    check("done_not_busy", 32'(busy), 32'd0);
    for (int i = 0; i < RESP_BITS; i++) begin
      check($sformatf("measure_len[%0d]", i), 32'(mlen[i]), 32'(exp_mlen[i]));
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("idle_resp_hold", 32'(response), 32'(e.resp));
    check("idle_err_hold", 32'(timeout_err), 32'(e.err));
    check("idle_idx_hold", 32'(chal_idx), 32'(RESP_BITS - 1));
  endtask

  initial begin
    set_tables(3, 1);

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ro_en", 32'(ro_en), 32'd0);
    check("rst_arb_rst", 32'(arb_rst), 32'd1);
    check("rst_response", 32'(response), 32'd0);
    check("rst_chal_idx", 32'(chal_idx), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arb_rst", 32'(arb_rst), 32'd0);

    // All oscillator-1 wins.
    set_tables(3, 1);
    launch(1'b1);
    wait_done(1'b0, 1'b0);

    // Index-dependent pattern with ignored start pulses while busy and during done.
    set_tables(3, 2);
    launch(1'b1);
    wait_done(1'b1, 1'b1);

    // Timeout at index 3.
    set_tables(3, 1);
    fin_tbl[3] = 0;
    launch(1'b1);
    wait_done(1'b0, 1'b0);

    // Next run clears timeout_err; finish in the same cycle as the timeout limit.
    set_tables(4, 1);
    fin_tbl[5] = TIMEOUT;
    launch(1'b1);
    wait_done(1'b0, 1'b0);

    // Finish one cycle too late counts as a timeout with a 0 bit.
    set_tables(2, 1);
    fin_tbl[6] = TIMEOUT + 1;
    launch(1'b1);
    wait_done(1'b1, 1'b0);

    // Reset in MEASURE at index 4, with start held alongside reset.
    set_tables(3, 1);
    launch(1'b0);
    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 500; n++) begin
        @(negedge clk);
        if (ro_en && chal_idx == IDX_W'(4)) begin
          hit = 1'b1;
          break;
        end
      end
      check("reach_idx4_measure", 32'(hit), 32'd1);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ro_en", 32'(ro_en), 32'd0);
    check("midrst_response", 32'(response), 32'd0);
    check("midrst_chal_idx", 32'(chal_idx), 32'd0);
    check("midrst_arb_rst", 32'(arb_rst), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);

    // Fresh start restarts from index 0.
    set_tables(5, 2);
    launch(1'b1);
    wait_done(1'b0, 1'b0);

    check("monitor_violations", 32'(mon_viol), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_response_collector.md
# puf_response_collector

Sequencer and response register sitting directly downstream of the ring-oscillator race arbiter. It steps through RESP_BITS challenges. For each challenge it:
- resets the arbiter and RO counters,
- enables the oscillators,
- waits for the arbiter's `finish`, or a timeout,
- captures the arbiter's `resp` bit.

The result is one RESP_BITS-wide PUF response word with a one-cycle `done` pulse. The challenge index drives the upstream RO-pair select mux.

## Interface

Parameters:
- RESP_BITS, 8: response width = number of challenges per run (>= 1).
- IDX_W, 3: challenge index width; 2**IDX_W >= RESP_BITS.
- CLR_CYCLES, 2: cycles `arb_rst` is held per challenge (>= 1).
- TIMEOUT, 255: maximum MEASURE cycles per challenge (>= 1); timer width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE, ignored otherwise.
- arb_resp  in  1  arbiter winner bit (1 = oscillator 1 won).
- arb_finish  in  1  arbiter decided flag (registered in arbiter).
- arb_rst  out  1  reset to arbiter and RO counters; = rst OR (state == CLEAR).
- ro_en  out  1  oscillator/counter enable; = (state == MEASURE).
- chal_idx  out  IDX_W  current challenge / RO-pair select.
- busy  out  1  high in CLEAR, MEASURE, CAPTURE.
- done  out  1  one-cycle pulse, run complete.
- response  out  RESP_BITS  collected word; bit i = result of challenge i.
- timeout_err  out  1  sticky: at least one challenge in the run timed out.

## Operation

States: IDLE, CLEAR, MEASURE, CAPTURE, DONE. `state`, `chal_idx`, timer, `response` and `timeout_err` are all registered.

- **IDLE:** all outputs quiet except `response` and `timeout_err`, which hold the last run's value.
  - On `start`: go to CLEAR; `chal_idx` <= 0; `response` <= 0; `timeout_err` <= 0; clear counter <= 0.
- **CLEAR:** `arb_rst` = 1, `ro_en` = 0.
  - Stay CLR_CYCLES cycles, then go to MEASURE with timer <= 0.
- **MEASURE:** `ro_en` = 1; timer increments each cycle.
  - If `arb_finish` = 1: latch `arb_resp` into the capture bit, go to CAPTURE.
  - Else if timer == TIMEOUT-1: latch 0 into the capture bit, set `timeout_err`, go to CAPTURE.
  - `arb_finish` takes priority over timeout when both happen in the same cycle.
- **CAPTURE:** `ro_en` = 0; `response[chal_idx]` <= capture bit.
  - If `chal_idx` == RESP_BITS-1: go to DONE.
  - Else: `chal_idx` <= `chal_idx`+1, go to CLEAR.
- **DONE:** `done` = 1 for exactly this cycle, then go to IDLE. `response` is final and stable from this cycle until the next accepted `start`.
- `chal_idx` never exceeds RESP_BITS-1. It holds its last value in DONE and IDLE.
- **Reset (`rst` = 1), at any time including mid-run:**
  - Next state IDLE.
  - `chal_idx` = 0, `response` = 0, `timeout_err` = 0, `done` = 0, `busy` = 0, `ro_en` = 0.
  - `arb_rst` = 1 combinationally for as long as `rst` is high.
  - A `start` asserted together with `rst` is ignored.

## Timing

- `start` sampled at edge E0: CLEAR occupies cycles 1..CLR_CYCLES.
- Because `arb_rst` is active in CLEAR, the arbiter's registered `finish` is 0 by the first MEASURE cycle. No stale `finish` is ever captured.
- If `arb_finish` is first high in MEASURE cycle m (1-based), MEASURE lasts m cycles. The timeout case lasts TIMEOUT cycles.
- Cycles per challenge = CLR_CYCLES + m + 1 (CAPTURE).
- `done` is asserted the cycle after the last CAPTURE. `response` is updated at the edge that ends each CAPTURE cycle.
- Latency from `start` to `done` = 1 + Σ(per-challenge cycles).
- Back-to-back runs: a `start` during DONE is ignored. The earliest accepted `start` is in the cycle after DONE.

## Test plan

- **Reset values:** assert `rst` 3 cycles.
  - Expect `busy`=0, `done`=0, `ro_en`=0, `arb_rst`=1 while `rst` is high, `response`=0x00, `chal_idx`=0, `timeout_err`=0.
- **All oscillator-1 wins:** RESP_BITS=8, CLR_CYCLES=2; model raises `finish` in MEASURE cycle 3 with `resp`=1.
  - Expect `response`=0xFF, `timeout_err`=0.
  - Expect 6 cycles per challenge, `done` pulse exactly 49 cycles after the `start` edge.
- **Index-dependent pattern:** model returns `resp` = `chal_idx[0]`.
  - Expect `response`=0xAA.
  - Expect `chal_idx` steps 0..7 and `ro_en` is high only in MEASURE.
- **Timeout:** TIMEOUT=16; model never finishes for `chal_idx`=3, otherwise `resp`=1.
  - Expect MEASURE lasts 16 cycles at index 3, `response`=0xF7, `timeout_err`=1.
  - Next `start` clears `timeout_err` to 0.
- **Finish and timeout together:** `finish`=1 with `resp`=1 in the exact cycle timer == TIMEOUT-1.
  - Expect the bit captured as 1 and `timeout_err`=0.
- **Reset mid-run and start handling:** pulse `rst` while `chal_idx`=4 in MEASURE.
  - Expect IDLE next cycle, `response`=0, `ro_en`=0.
  - `start` pulses during `busy` or DONE are ignored.
  - A fresh `start` restarts from `chal_idx`=0.
